// File: rtl/cdc_event_handshake_tx.sv
// Send side of the fast->slow event-count handshake: counts event strobes
// and ships each count to the receive domain under a 4-phase req/ack.
module cdc_event_handshake_tx #(
    parameter int COUNT_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               in_clk_send,
    input  logic               in_reset_send,
    input  logic               in_event,
    input  logic               in_ack,
    input  logic               in_clear_overflow,
    output logic               out_req,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_busy,
    output logic               out_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    localparam logic [COUNT_W-1:0] ACC_MAX = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [COUNT_W-1:0]     acc;
    logic                   ack_s;
    logic                   launch;
    logic                   acc_full;
    logic                   drop;

    assign ack_s    = sync[SYNC_STAGES-1];
    assign launch   = (state == IDLE) && (acc != '0);
    assign acc_full = (acc == ACC_MAX);
    // The event on a launch cycle goes to the next transfer, so it never drops.
    assign drop     = in_event && !launch && acc_full;

    always_ff @(posedge in_clk_send or posedge in_reset_send) begin
        if (in_reset_send) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_ack};
        end
    end

    always_ff @(posedge in_clk_send or posedge in_reset_send) begin
        if (in_reset_send) begin
            acc <= '0;
        end else if (launch) begin
            acc <= {{(COUNT_W-1){1'b0}}, in_event};
        end else if (in_event && !acc_full) begin
            acc <= acc + COUNT_W'(1);
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge in_clk_send or posedge in_reset_send) begin
        if (in_reset_send) begin
            out_overflow <= 1'b0;
        end else if (drop) begin
            out_overflow <= 1'b1;
        end else if (in_clear_overflow) begin
            out_overflow <= 1'b0;
        end
    end

    always_ff @(posedge in_clk_send or posedge in_reset_send) begin
        if (in_reset_send) begin
            state     <= IDLE;
            out_req   <= 1'b0;
            out_busy  <= 1'b0;
            out_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        out_count <= acc;
                        out_req   <= 1'b1;
                        out_busy  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        out_req <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        out_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    out_req  <= 1'b0;
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_event_handshake_tx.sv
// Bench for cdc_event_handshake_tx: directed scenarios checked every cycle
// against a behavioural event/transfer model plus literal expectations.
module tb_cdc_event_handshake_tx;

    localparam int COUNT_W = 8;
    localparam int SYNC    = 2;
    localparam int MAXV    = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               ev;
    logic               ack;
    logic               clr;
    logic               req;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    // model state
    int             m_acc, m_count, m_ph;
    bit             m_req, m_busy, m_ovf;
    bit [SYNC-1:0]  m_sync;
    longint         received, dropped;

    // observed transfers
    longint         done_sum;
    int             done_cnt;
    int             launches[$];
    bit             prev_busy;
    logic [COUNT_W-1:0] prev_count;

    // automatic receiver
    bit auto_ack = 0;
    int ack_wait = 0;
    int ack_delay = 3;

    cdc_event_handshake_tx #(
        .COUNT_W    (COUNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .in_clk_send      (clk),
        .in_reset_send    (rst),
        .in_event         (ev),
        .in_ack           (ack),
        .in_clear_overflow(clr),
        .out_req          (req),
        .out_count        (count),
        .out_busy         (busy),
        .out_overflow     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_count = 0; m_ph = 0;
        m_req = 0; m_busy = 0; m_ovf = 0; m_sync = '0;
        received = 0; dropped = 0; done_sum = 0; done_cnt = 0;
        launches.delete();
        prev_busy = 0; prev_count = '0;
    endtask

    // One clock edge in terms of events, transfers and the ack as seen
    // through SYNC flops.
    task automatic model_edge();
        bit seen;
        bit go;
        bit lost;
        seen = m_sync[SYNC-1];
        go   = (m_ph == 0) && (m_acc != 0);
        lost = ev && !go && (m_acc == MAXV);
        if (ev) received++;
        if (lost) dropped++;
        if (go) begin
            m_count = m_acc;
            m_acc   = ev ? 1 : 0;
            m_req   = 1; m_busy = 1; m_ph = 1;
        end else begin
            if (ev && m_acc < MAXV) m_acc++;
            if (m_ph == 1 && seen) begin
                m_req = 0; m_ph = 2;
            end else if (m_ph == 2 && !seen) begin
                m_busy = 0; m_ph = 0;
            end
        end
        if (lost) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_sync = {m_sync[SYNC-2:0], ack};
    endtask

    task automatic compare();
        chk("req", req, m_req);
        chk("busy", busy, m_busy);
        chk("count", count, m_count);
        chk("overflow", ovf, m_ovf);
        if (prev_busy && busy) chk("count_stable", count, prev_count);
        if (!prev_busy && busy) launches.push_back(int'(count));
        if (prev_busy && !busy) begin
            done_cnt++;
            done_sum += prev_count;
        end
        prev_busy  = busy;
        prev_count = count;
    endtask

    task automatic tick(input bit e, input bit c);
        ev  = e;
        clr = c;
        if (auto_ack) begin
            if (ack != req) begin
                if (ack_wait >= ack_delay) begin
                    ack       = req;
                    ack_wait  = 0;
                    ack_delay = $urandom_range(1, 20);
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic manual_handshake();
        ack = 1;
        repeat (3) tick(0, 0);
        ack = 0;
        repeat (3) tick(0, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        auto_ack = 1;
        while (!(m_ph == 0 && m_acc == 0 && !busy) && n < 1000) begin
            tick(0, 0);
            n++;
        end
        chk("drain_bound", n < 1000, 1);
        repeat (2) tick(0, 0);
    endtask

    initial begin
        int d0;
        rst = 1; ev = 0; ack = 0; clr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 0;
        repeat (3) tick(0, 0);

        // single event, manual ack
        tick(1, 0);
        chk("t1_req_lat", req, 0);
        tick(0, 0);
        chk("t1_req_up", req, 1);
        chk("t1_busy_up", busy, 1);
        chk("t1_count", count, 1);
        repeat (3) tick(0, 0);
        ack = 1;
        repeat (2) tick(0, 0);
        chk("t1_req_hold", req, 1);
        tick(0, 0);
        chk("t1_req_down", req, 0);
        chk("t1_busy_rel", busy, 1);
        ack = 0;
        repeat (2) tick(0, 0);
        chk("t1_busy_hold", busy, 1);
        tick(0, 0);
        chk("t1_idle", busy, 0);

        // events during a transfer, plus one on the launch cycle
        tick(1, 0);
        tick(0, 0);
        repeat (3) tick(1, 0);
        manual_handshake();
        chk("t2_idle", busy, 0);
        tick(1, 0);
        chk("t2_count3", count, 3);
        manual_handshake();
        tick(0, 0);
        chk("t2_count1", count, 1);
        manual_handshake();
        chk("t2_launches", launches.size(), 4);

        // saturation with ack held low
        for (int i = 1; i <= 300; i++) begin
            tick(1, 0);
            if (i == 256) chk("t3_ovf_256", ovf, 0);
            if (i == 257) chk("t3_ovf_257", ovf, 1);
        end
        chk("t3_count", count, 1);
        tick(1, 1);
        chk("t3_set_wins", ovf, 1);
        tick(0, 1);
        chk("t3_cleared", ovf, 0);
        drain();
        chk("t3_dropped", dropped, 45);

        // sub-cycle ack glitch while in REQ
        auto_ack = 0;
        ack = 0;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        #2 ack = 1;
        #2 ack = 0;
        repeat (3) tick(0, 0);
        chk("t6_no_release", req, 1);
        d0 = done_cnt;
        drain();
        chk("t6_once", done_cnt - d0, 1);

        // random traffic with random ack delays
        for (int i = 0; i < 10000; i++)
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
        drain();
        chk("t4_conserve", done_sum, received - dropped);

        // async reset in REQ with acc=4
        auto_ack = 0;
        ack = 0;
        tick(1, 0);
        tick(0, 0);
        repeat (4) tick(1, 0);
        chk("t5_in_req", req, 1);
        ev = 0;
        #2 rst = 1;
        #1;
        chk("t5_req0", req, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_count0", count, 0);
        chk("t5_ovf0", ovf, 0);
        model_clear();
        @(negedge clk);
        rst = 0;
        repeat (3) tick(0, 0);
        chk("t5_no_launch", busy, 0);
        chk("t5_launches", launches.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
